// File: rtl/gen_stream_ctrl_if.sv
// Source/buffer bus between the stream sequencer and its neighbours.
//   master : sequencer view (drives src_en, buf_wr_en, buf_wr_data)
//   slave  : generator/buffer view (drives src_valid, src_data, buf_full, buf_empty)
// Channel i data lives in src_data[i*DATA_W +: DATA_W].
interface gen_stream_ctrl_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DATA_W = 16
);
    logic [N_CH-1:0]        src_valid;
    logic [N_CH*DATA_W-1:0] src_data;
    logic [N_CH-1:0]        src_en;
    logic                   buf_full;
    logic                   buf_empty;
    logic                   buf_wr_en;
    logic [DATA_W-1:0]      buf_wr_data;

    modport master (
        input  src_valid, src_data, buf_full, buf_empty,
        output src_en, buf_wr_en, buf_wr_data
    );

    modport slave (
        output src_valid, src_data, buf_full, buf_empty,
        input  src_en, buf_wr_en, buf_wr_data
    );
endinterface

// File: rtl/gen_stream_ctrl.sv
// Sequencer moving words from N_CH generator channels into one buffer write port.
// Handles source enables, buffer back-pressure, stop/drain and fixed or
// round-robin channel selection.
//   clock, reset  : system clock (rising edge), async active-low reset
//   start         : per-channel start request (level)
//   rr_mode       : round-robin select, latched when leaving IDLE
//   stop          : stop request, wins over start in every state
//   bus           : source valid/data/enable and buffer full/empty/write
//   parity        : XOR of last written word
//   active_ch     : currently selected channel
//   state_out     : 0=IDLE 1=COMM 2=WAIT 3=BUF_EMPTY
//   word_cnt      : words written since last start, saturating
module gen_stream_ctrl #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CH_W     = 1,
    parameter int unsigned RR_BURST = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic                  rr_mode,
    input  logic                  stop,
    gen_stream_ctrl_if.master     bus,
    output logic                  parity,
    output logic [CH_W-1:0]       active_ch,
    output logic [1:0]            state_out,
    output logic [15:0]           word_cnt
);

    localparam int unsigned BURST_W = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMM      = 2'd1,
        ST_WAIT      = 2'd2,
        ST_BUF_EMPTY = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [BURST_W-1:0]   burst_q;
    logic [BURST_W-1:0]   burst_d;
    logic                 rr_q;
    logic                 rr_d;
    logic [CH_W-1:0]      ch_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 parity_d;
    logic                 wr_en_q;
    logic                 wr_en_d;
    logic [DATA_W-1:0]    wr_data_q;
    logic [DATA_W-1:0]    wr_data_d;

    logic [N_CH-1:0]      cur_onehot;
    logic [N_CH-1:0]      other_start;
    logic                 sel_valid;
    logic [DATA_W-1:0]    sel_data;
    logic                 accept;
    logic [CH_W-1:0]      ch_next_rr;
    logic [BURST_W-1:0]   burst_inc;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [CH_W-1:0] lowest_bit(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Channel decode and data/valid select for the active channel.
    always_comb begin
        cur_onehot = '0;
        sel_data   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cur_onehot[i] = (active_ch == CH_W'(i));
            if (active_ch == CH_W'(i)) sel_data = bus.src_data[i*DATA_W +: DATA_W];
        end
    end

    assign sel_valid   = |(bus.src_valid & cur_onehot);
    assign other_start = start & ~cur_onehot;
    assign accept      = (state_q == ST_COMM) && !bus.buf_full && sel_valid;
    assign burst_inc   = burst_q + BURST_W'(1);
    // Explicit wrap keeps active_ch below N_CH when N_CH is not a power of two.
    assign ch_next_rr  = (active_ch == CH_W'(N_CH - 1)) ? '0 : active_ch + CH_W'(1);

    assign bus.src_en      = ((state_q == ST_COMM) && !bus.buf_full) ? cur_onehot : '0;
    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_data = wr_data_q;
    assign state_out       = state_q;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; stop takes priority everywhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && (|start)) state_d = ST_COMM;
            end
            ST_COMM: begin
                if (stop)              state_d = ST_BUF_EMPTY;
                else if (bus.buf_full) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (stop)              state_d = ST_BUF_EMPTY;
                else if (!bus.buf_full) state_d = ST_COMM;
            end
            ST_BUF_EMPTY: begin
                // Wait until the last strobe has gone out and the buffer has drained.
                if (bus.buf_empty && !wr_en_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and channel bookkeeping.
    always_comb begin
        wr_en_d   = accept;
        wr_data_d = accept ? sel_data : wr_data_q;
        parity_d  = accept ? ^sel_data : parity;
        cnt_d     = (accept && (word_cnt != 16'hFFFF)) ? word_cnt + CNT_W'(1) : word_cnt;
        ch_d      = active_ch;
        burst_d   = burst_q;
        rr_d      = rr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!stop && (|start)) begin
                    ch_d    = lowest_bit(start);
                    cnt_d   = '0;
                    burst_d = '0;
                    rr_d    = rr_mode;
                end
            end
            ST_COMM: begin
                if (!stop) begin
                    if (rr_q) begin
                        if (accept) begin
                            if (burst_inc == BURST_W'(RR_BURST)) begin
                                burst_d = '0;
                                ch_d    = ch_next_rr;
                            end else begin
                                burst_d = burst_inc;
                            end
                        end
                    end else if (!bus.buf_full && (|other_start)) begin
                        ch_d    = lowest_bit(other_start);
                        burst_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            parity    <= 1'b0;
            word_cnt  <= '0;
            active_ch <= '0;
            burst_q   <= '0;
            rr_q      <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            parity    <= parity_d;
            word_cnt  <= cnt_d;
            active_ch <= ch_d;
            burst_q   <= burst_d;
            rr_q      <= rr_d;
        end
    end

endmodule
